// File: rtl/act_requant_writer_pkg.sv
// Shared widths and state type for the requantizing activation writer.
// Widths must line up with the pooling stage that reads activation memory.
package act_requant_writer_pkg;
  localparam int N_DIM_ARRAY = 16;
  localparam int ACC_WIDTH   = 32;
  localparam int DATA_WIDTH  = 8;
  localparam int ADDR_WIDTH  = 16;
  localparam int CNT_WIDTH   = 16;
  localparam int SHIFT_WIDTH = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Shifts past ACC_WIDTH-1 collapse to ACC_WIDTH-1.
  function automatic logic [SHIFT_WIDTH-1:0] eff_shift(input logic [7:0] i_sh);
    return (i_sh > 8'(ACC_WIDTH - 1)) ? SHIFT_WIDTH'(ACC_WIDTH - 1) : i_sh[SHIFT_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/act_requant_writer_if.sv
// Accumulator input stream and activation memory write port.
interface act_requant_writer_if;
  import act_requant_writer_pkg::*;

  logic                                   in_valid;
  logic                                   in_ready;
  logic [N_DIM_ARRAY-1:0][ACC_WIDTH-1:0]  acc_word;
  logic                                   wr_en;
  logic [ADDR_WIDTH-1:0]                  wr_addr;
  logic [N_DIM_ARRAY-1:0][DATA_WIDTH-1:0] wr_word;

  modport master (output in_valid, acc_word, input in_ready, wr_en, wr_addr, wr_word);
  modport slave  (input in_valid, acc_word, output in_ready, wr_en, wr_addr, wr_word);
endinterface

// File: rtl/act_requant_writer_requant_lane.sv
// One lane: round-half-up arithmetic shift, and separately saturate + ReLU.
// Both halves are combinational; the parent registers between them.
module requant_lane
  import act_requant_writer_pkg::*;
(
  input  logic [ACC_WIDTH-1:0]   i_acc,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  output logic [ACC_WIDTH-1:0]   o_round,
  input  logic [ACC_WIDTH-1:0]   i_round,
  input  logic                   i_relu,
  output logic [DATA_WIDTH-1:0]  o_act
);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ~SAT_HI;

  logic [ACC_WIDTH:0]          w_unit;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic signed [ACC_WIDTH:0]   w_shr;
  logic signed [ACC_WIDTH-1:0] w_r;

  // One extra bit of headroom so the rounding bias cannot overflow;
  // a zero shift yields a zero bias and passes the value through.
  always_comb begin
    w_unit  = (ACC_WIDTH + 1)'(1) << i_shift;
    w_sum   = $signed({i_acc[ACC_WIDTH-1], i_acc}) + $signed({1'b0, w_unit[ACC_WIDTH:1]});
    w_shr   = w_sum >>> i_shift;
    o_round = w_shr[ACC_WIDTH-1:0];
  end

  always_comb begin
    w_r = $signed(i_round);
    if (w_r > SAT_HI)      o_act = SAT_HI[DATA_WIDTH-1:0];
    else if (w_r < SAT_LO) o_act = SAT_LO[DATA_WIDTH-1:0];
    else                   o_act = w_r[DATA_WIDTH-1:0];
    if (i_relu && o_act[DATA_WIDTH-1]) o_act = '0;
  end
endmodule

// File: rtl/act_requant_writer.sv
// Requantizes accumulator vectors from the PE drain and writes them to
// consecutive activation memory addresses, one job per start pulse.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | accepting vectors until num_words taken
// ST_DRAIN | waiting for the 2-stage pipeline to empty
// ST_DONE  | one-cycle done pulse
module act_requant_writer
  import act_requant_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic [7:0]            shift,
  input  logic                  relu_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  act_requant_writer_if.slave   bus
);
  state_t                                 r_state;
  state_t                                 w_state_nxt;
  logic [CNT_WIDTH-1:0]                   r_remain;
  logic [SHIFT_WIDTH-1:0]                 r_shift;
  logic                                   r_relu;
  logic [ADDR_WIDTH-1:0]                  r_addr;
  logic                                   r_v1;
  logic [N_DIM_ARRAY-1:0][ACC_WIDTH-1:0]  r_stage1;
  logic [N_DIM_ARRAY-1:0][ACC_WIDTH-1:0]  w_round;
  logic [N_DIM_ARRAY-1:0][DATA_WIDTH-1:0] w_act;
  logic                                   w_start_ok;
  logic                                   w_accept;

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_accept   = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Stage 2 always empties on the edge after stage 1 does, so leaving
  // DRAIN once stage 1 is clear lands done right after the final write.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = (num_words == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_accept && (r_remain == CNT_WIDTH'(1))) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!r_v1) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (r_state == ST_RUN) && (r_remain != '0);
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remain <= '0;
      r_shift  <= '0;
      r_relu   <= 1'b0;
    end else if (w_start_ok) begin
      r_remain <= num_words;
      r_shift  <= eff_shift(shift);
      r_relu   <= relu_en;
    end else if (w_accept) begin
      r_remain <= r_remain - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1        <= 1'b0;
      r_stage1    <= '0;
      r_addr      <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_word <= '0;
    end else begin
      r_v1      <= w_accept;
      bus.wr_en <= r_v1;
      if (w_accept) r_stage1 <= w_round;
      if (w_start_ok) begin
        r_addr <= base_addr;
      end else if (r_v1) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        bus.wr_addr <= r_addr;
        bus.wr_word <= w_act;
      end
    end
  end

  for (genvar g = 0; g < N_DIM_ARRAY; g++) begin : g_lane
    requant_lane u_lane (
      .i_acc   (bus.acc_word[g]),
      .i_shift (r_shift),
      .o_round (w_round[g]),
      .i_round (r_stage1[g]),
      .i_relu  (r_relu),
      .o_act   (w_act[g])
    );
  end
endmodule

// File: tb/tb_act_requant_writer.sv
// Directed and randomized jobs against a transaction-level reference model.
module tb_act_requant_writer;
  import act_requant_writer_pkg::*;

  localparam int AW = N_DIM_ARRAY * ACC_WIDTH;
  localparam int WW = N_DIM_ARRAY * DATA_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [CNT_WIDTH-1:0]  num_words;
  logic [7:0]            shift;
  logic                  relu_en;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  busy;
  logic                  done;

  act_requant_writer_if bus();

  act_requant_writer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .shift     (shift),
    .relu_en   (relu_en),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit                    m_idle = 1'b1;
  int                    m_remain = 0;
  int                    m_shift = 0;
  bit                    m_relu = 1'b0;
  logic [ADDR_WIDTH-1:0] m_addr = '0;
  bit                    m_done_now = 1'b0;
  bit                    d1_v = 1'b0, d2_v = 1'b0, d1_last = 1'b0, d2_last = 1'b0;
  logic [ADDR_WIDTH-1:0] d1_a = '0, d2_a = '0;
  logic [WW-1:0]         d1_w = '0, d2_w = '0;
  bit                    last_acc = 1'b0;
  int                    acc_cnt = 0;
  bit                    e_ready, acc_now, nxt_done;
  logic [ADDR_WIDTH-1:0] obs_a[$];
  logic [WW-1:0]         obs_w[$];
  logic [AW-1:0]         vecs[$];

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] ref_lane(input logic [ACC_WIDTH-1:0] acc, input int sh, input bit relu);
    longint a, r;
    int s;
    s = (sh > ACC_WIDTH - 1) ? ACC_WIDTH - 1 : sh;
    a = longint'($signed(acc));
    if (s > 0) r = (a + (longint'(1) << (s - 1))) >>> s;
    else       r = a;
    if (r > (2 ** (DATA_WIDTH - 1)) - 1) r = (2 ** (DATA_WIDTH - 1)) - 1;
    if (r < -(2 ** (DATA_WIDTH - 1)))    r = -(2 ** (DATA_WIDTH - 1));
    if (relu && r < 0) r = 0;
    return DATA_WIDTH'(r);
  endfunction

  function automatic logic [WW-1:0] ref_vec(input logic [AW-1:0] v, input int sh, input bit relu);
    logic [WW-1:0] r;
    r = '0;
    for (int i = 0; i < N_DIM_ARRAY; i++)
      r[i*DATA_WIDTH +: DATA_WIDTH] = ref_lane(v[i*ACC_WIDTH +: ACC_WIDTH], sh, relu);
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_vec();
    logic [AW-1:0] v;
    int t;
    for (int i = 0; i < N_DIM_ARRAY; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v[i*ACC_WIDTH +: ACC_WIDTH] = $urandom;
      end else begin
        t = int'($urandom_range(0, 4000)) - 2000;
        v[i*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(t);
      end
    end
    return v;
  endfunction

  // Per-cycle model: expected ready/busy/done and writes two cycles after each accept.
  always @(negedge clk) begin
    if (reset) begin
      m_idle = 1'b1; m_remain = 0; m_done_now = 1'b0;
      d1_v = 1'b0; d2_v = 1'b0; d1_last = 1'b0; d2_last = 1'b0;
      last_acc = 1'b0;
    end else begin
      e_ready = !m_idle && (m_remain > 0);
      chk("in_ready", WW'(bus.in_ready), WW'(e_ready));
      chk("busy", WW'(busy), WW'(!m_idle));
      chk("done", WW'(done), WW'(m_done_now));
      chk("wr_en", WW'(bus.wr_en), WW'(d2_v));
      if (d2_v) begin
        chk("wr_addr", WW'(bus.wr_addr), WW'(d2_a));
        chk("wr_word", WW'(bus.wr_word), d2_w);
      end
      if (bus.wr_en) begin
        obs_a.push_back(bus.wr_addr);
        obs_w.push_back(WW'(bus.wr_word));
      end
      acc_now  = bus.in_valid && e_ready;
      last_acc = acc_now;
      nxt_done = d2_v && d2_last;
      d2_v = d1_v; d2_a = d1_a; d2_w = d1_w; d2_last = d1_last;
      d1_v = acc_now; d1_a = m_addr; d1_last = acc_now && (m_remain == 1);
      d1_w = ref_vec(AW'(bus.acc_word), m_shift, m_relu);
      if (acc_now) begin
        m_remain--;
        m_addr++;
        acc_cnt++;
      end
      if (start && m_idle) begin
        m_idle = 1'b0;
        if (num_words == 0) begin
          nxt_done = 1'b1;
        end else begin
          m_remain = int'(num_words);
          m_shift  = int'(shift);
          m_relu   = relu_en;
          m_addr   = base_addr;
        end
      end else if (m_done_now) begin
        m_idle = 1'b1;
      end
      m_done_now = nxt_done;
    end
  end

  // vmode: 0 valid held high, 1 valid pattern 1,0,0,1, 2 random valid.
  task automatic run_job(input int nw, input int sh, input bit relu, input logic [ADDR_WIDTH-1:0] base,
                         input int vmode, input int spur);
    int idx;
    int c;
    obs_a.delete();
    obs_w.delete();
    @(posedge clk); #1;
    start = 1'b1; num_words = CNT_WIDTH'(nw); shift = 8'(sh); relu_en = relu; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    for (c = 0; c < 300; c++) begin
      if (m_idle) break;
      bus.acc_word = (idx < vecs.size()) ? vecs[idx] : rand_vec();
      case (vmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = ((c % 4) == 0) || ((c % 4) == 3);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      if (c == spur) begin
        start = 1'b1; num_words = 16'd7; base_addr = 16'h5555; shift = 8'd3; relu_en = !relu;
      end
      @(posedge clk); #1;
      start = 1'b0; num_words = CNT_WIDTH'(nw); shift = 8'(sh); relu_en = relu; base_addr = base;
      if (last_acc) idx++;
    end
    bus.in_valid = 1'b0;
    if (c >= 300) begin
      n_cmp++;
      n_err++;
      $error("FAIL job_timeout: got busy after %0d cycles, want idle", c);
    end
  endtask

  initial begin
    logic [AW-1:0] v;
    reset = 1'b1; start = 1'b0; num_words = '0; shift = '0; relu_en = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0; bus.acc_word = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", WW'(bus.in_ready), '0);
    chk("rst_wr_en", WW'(bus.wr_en), '0);
    chk("rst_wr_addr", WW'(bus.wr_addr), '0);
    chk("rst_wr_word", WW'(bus.wr_word), '0);
    chk("rst_busy", WW'(busy), '0);
    chk("rst_done", WW'(done), '0);
    reset = 1'b0;

    // basic job
    vecs.delete();
    v = rand_vec(); v[31:0] = 32'd100;        vecs.push_back(v);
    v = rand_vec(); v[31:0] = 32'hFFFF_FF9C;  vecs.push_back(v);
    v = rand_vec(); v[31:0] = 32'h7FFF_FFFF;  vecs.push_back(v);
    run_job(3, 4, 1'b0, 16'h0010, 0, -1);
    chk("basic_nwr", WW'(obs_a.size()), WW'(3));
    if (obs_a.size() == 3) begin
      chk("basic_a0", WW'(obs_a[0]), WW'(16'h0010));
      chk("basic_a2", WW'(obs_a[2]), WW'(16'h0012));
      chk("basic_l0_0", WW'(obs_w[0][7:0]), WW'(8'd6));
      chk("basic_l0_1", WW'(obs_w[1][7:0]), WW'(8'hFA));
      chk("basic_l0_2", WW'(obs_w[2][7:0]), WW'(8'd127));
    end

    // rounding and ReLU
    vecs.delete();
    v = rand_vec();
    v[31:0] = 32'd3; v[63:32] = 32'hFFFF_FFFD; v[95:64] = 32'd1; v[127:96] = 32'hFFFF_FFFF;
    vecs.push_back(v);
    run_job(1, 1, 1'b1, 16'h0040, 0, -1);
    if (obs_w.size() == 1) chk("relu_on", WW'(obs_w[0][31:0]), WW'(32'h0001_0002));
    run_job(1, 1, 1'b0, 16'h0041, 0, -1);
    if (obs_w.size() == 1) chk("relu_off", WW'(obs_w[0][31:0]), WW'(32'h0001_FF02));

    // saturation and oversized shift
    vecs.delete();
    v = rand_vec(); v[31:0] = 32'd200; v[63:32] = 32'hFFFF_FF38; vecs.push_back(v);
    run_job(1, 0, 1'b0, 16'h0050, 0, -1);
    if (obs_w.size() == 1) chk("sat", WW'(obs_w[0][15:0]), WW'(16'h807F));
    vecs.delete();
    v = rand_vec(); v[31:0] = 32'hFFFF_FFFB; v[63:32] = 32'd5; vecs.push_back(v);
    run_job(1, 40, 1'b0, 16'h0051, 0, -1);
    if (obs_w.size() == 1) chk("shift40", WW'(obs_w[0][15:0]), '0);

    // bubbles and address wrap
    vecs.delete();
    run_job(2, 3, 1'b0, 16'hFFFF, 1, -1);
    chk("wrap_nwr", WW'(obs_a.size()), WW'(2));
    if (obs_a.size() == 2) begin
      chk("wrap_a0", WW'(obs_a[0]), WW'(16'hFFFF));
      chk("wrap_a1", WW'(obs_a[1]), WW'(16'h0000));
    end

    // zero-length job and start ignored during RUN
    run_job(0, 2, 1'b0, 16'h0100, 0, -1);
    chk("zero_nwr", WW'(obs_a.size()), '0);
    run_job(5, 2, 1'b0, 16'h0200, 0, 2);
    chk("spur_nwr", WW'(obs_a.size()), WW'(5));
    if (obs_a.size() == 5) chk("spur_alast", WW'(obs_a[4]), WW'(16'h0204));

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      int nw;
      nw = int'($urandom_range(1, 12));
      run_job(nw, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
              ADDR_WIDTH'($urandom), 2, (j == 3) ? 1 : -1);
      chk("rand_nwr", WW'(obs_a.size()), WW'(nw));
    end

    // reset mid-job
    vecs.delete();
    obs_a.delete();
    @(posedge clk); #1;
    start = 1'b1; num_words = 16'd4; shift = 8'd2; relu_en = 1'b0; base_addr = 16'h0700;
    @(posedge clk); #1;
    start = 1'b0;
    acc_cnt = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20 && acc_cnt < 2; c++) begin
      bus.acc_word = rand_vec();
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", WW'(bus.wr_en), '0);
    chk("mid_rst_wr_addr", WW'(bus.wr_addr), '0);
    chk("mid_rst_wr_word", WW'(bus.wr_word), '0);
    chk("mid_rst_busy", WW'(busy), '0);
    chk("mid_rst_in_ready", WW'(bus.in_ready), '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_rst_hold_wr_en", WW'(bus.wr_en), '0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_nwr", WW'(obs_a.size()), WW'(1));
    run_job(4, 5, 1'b1, 16'h0300, 0, -1);
    chk("post_rst_nwr", WW'(obs_a.size()), WW'(4));
    if (obs_a.size() == 4) chk("post_rst_a3", WW'(obs_a[3]), WW'(16'h0303));

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/act_requant_writer.md
Name: act_requant_writer

Overview:
- Upstream neighbour of the nonlinear/pooling stage.
- Accepts N-wide signed accumulator vectors from the PE array drain. Each lane is requantized (round-half-up arithmetic right shift, then saturation to activation width, then optional ReLU).
- Writes each resulting N-wide activation word to the activation memory at consecutive addresses. The pooling stage later reads those addresses.
- Runs one job per start pulse and signals completion with a done pulse.

Parameters:
- N_DIM_ARRAY, 16, lanes per vector; equals PE array dimension.
- ACC_WIDTH, 32, signed accumulator width per lane.
- DATA_WIDTH, 8, signed activation width per lane; equals INPUT_CHANNEL_DATA_WIDTH.
- ADDR_WIDTH, 16, activation memory address width; equals INPUT_CHANNEL_ADDR_SIZE.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, single-cycle job start; sampled only in IDLE.
- num_words, input, 16, vectors in the job; sampled at start.
- shift, input, 8, right-shift amount; sampled at start.
- relu_en, input, 1, clamp negative results to 0; sampled at start.
- base_addr, input, ADDR_WIDTH, first write address; sampled at start.
- in_valid, input, 1, acc_word is valid this cycle.
- in_ready, output, 1, block accepts acc_word this cycle.
- acc_word, input, N_DIM_ARRAY x ACC_WIDTH signed, accumulator vector.
- wr_en, output, 1, activation memory write strobe.
- wr_addr, output, ADDR_WIDTH, write address.
- wr_word, output, N_DIM_ARRAY x DATA_WIDTH signed, requantized vector.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse at job end.

Behaviour:
- Reset: state IDLE; all counters 0; pipeline valid bits 0. Outputs in_ready=0, wr_en=0, wr_addr=0, wr_word all 0, busy=0, done=0.
- Reset asserted mid-job aborts the job. No wr_en is issued after reset asserts; in-flight data is discarded.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start when num_words>0.
  - IDLE -> DONE on start when num_words==0. No writes occur; done pulses the following cycle.
  - RUN -> DRAIN when the accepted count reaches num_words.
  - DRAIN -> DONE when both pipeline valid bits are 0.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- start outside IDLE is ignored. Job registers do not change.
- Handshake: a transfer occurs when in_valid and in_ready are both high. in_ready = (state==RUN) and (accepted<num_words). There is no downstream backpressure; the memory always accepts a write.
- Pipeline: fixed 2-cycle latency. A vector accepted at cycle t produces wr_en=1 at t+2 with its data on wr_word. Back-to-back vectors give one write per cycle.
- Stage 1 (registered), per lane:
  - Effective shift s = min(shift, ACC_WIDTH-1).
  - If s>0, r = (acc + 2^(s-1)) >>> s, computed in ACC_WIDTH+1 bits so the add cannot overflow.
  - If s==0, r = acc.
- Stage 2 (registered), per lane:
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Then, if relu_en and the value is negative, the lane is 0.
- Addressing: first write at base_addr; each subsequent write at +1. Wraps modulo 2^ADDR_WIDTH with no error.
- wr_addr and wr_word hold their last values when wr_en=0. They are 0 after reset.
- busy=1 in RUN, DRAIN and DONE.
- Write count per job equals num_words exactly. Extra in_valid cycles beyond num_words are not accepted.

Decomposition:
- Shared parameters package holds N_DIM_ARRAY, ACC_WIDTH, DATA_WIDTH, ADDR_WIDTH and the state enum typedef. Widths must match the pooling stage's read side.
- Sub-module requant_lane is one lane's combinational round/shift and saturate/ReLU, instantiated N_DIM_ARRAY times. The pipeline registers stay in the parent.

Test Plan:
- Basic job: num_words=3, shift=4, relu_en=0, base_addr=0x10; lane0 inputs 100, -100, 0x7FFFFFFF across the 3 vectors, in_valid held high -> wr_addr 0x10, 0x11, 0x12 at accept+2; lane0 outputs 6, -6, 127; done pulse 1 cycle after the last write.
- Rounding and ReLU: shift=1, relu_en=1, lanes {3, -3, 1, -1} -> {2, 0, 1, 0}. Then with relu_en=0 the same lanes give {2, -1, 1, 0}.
- Saturation and large shift:
  - shift=0, lanes {200, -200} -> {127, -128}.
  - shift=40, lanes {-5, 5} -> s=31, outputs {0, 0}.
- Bubbles and wrap: base_addr=0xFFFF, num_words=2, in_valid toggled 1,0,0,1 -> writes at 0xFFFF then 0x0000, each exactly 2 cycles after its accept; in_ready drops after the 2nd accept.
- Edge control:
  - num_words=0 start -> done one cycle later, wr_en never asserts.
  - start pulsed during RUN -> ignored.
- Reset mid-job: assert reset one cycle after the 2nd accept of a 4-word job -> outputs go to reset values immediately, no further wr_en. A new job after reset deasserts completes normally.
